// File: rtl/uart_alu_ctrl_pkg.sv
// Shared ALU definitions: default widths and the opcode set the sequencer accepts.
// The ALU and the sequencer both import this package.
package uart_alu_ctrl_pkg;

    localparam int DBIT_DEF  = 8;
    localparam int NB_OP_DEF = 6;

    localparam logic [NB_OP_DEF-1:0] OP_ADD = 6'b100000;
    localparam logic [NB_OP_DEF-1:0] OP_SUB = 6'b100010;
    localparam logic [NB_OP_DEF-1:0] OP_AND = 6'b100100;
    localparam logic [NB_OP_DEF-1:0] OP_OR  = 6'b100101;
    localparam logic [NB_OP_DEF-1:0] OP_XOR = 6'b100110;
    localparam logic [NB_OP_DEF-1:0] OP_NOR = 6'b100111;
    localparam logic [NB_OP_DEF-1:0] OP_SRA = 6'b000011;
    localparam logic [NB_OP_DEF-1:0] OP_SRL = 6'b000010;

    function automatic logic is_legal_op(input logic [NB_OP_DEF-1:0] op);
        logic legal;
        legal = 1'b0;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_XOR, OP_NOR, OP_SRA, OP_SRL: legal = 1'b1;
            default:                        legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/uart_alu_ctrl_frame_timer.sv
// Inter-byte timeout counter: counts enabled cycles since the last clear and
// saturates at TIMEOUT-1, which is also the expiry condition.
module uart_alu_ctrl_frame_timer #(
    parameter int TIMEOUT = 50000,
    parameter int TW      = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);

    logic [TW-1:0] r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable && (r_count != LAST)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign expired = (r_count == LAST);

endmodule

// File: rtl/uart_alu_ctrl.sv
// Frame sequencer between UART RX FIFO, combinational ALU and UART TX FIFO.
// Frames are A, B, opcode; the one-byte result is pushed once the TX FIFO has room.
module uart_alu_ctrl
    import uart_alu_ctrl_pkg::*;
#(
    parameter int DBIT    = DBIT_DEF,
    parameter int NB_OP   = NB_OP_DEF,
    parameter int TIMEOUT = 50000,
    parameter int TW      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rx_empty,
    input  logic [DBIT-1:0]  rx_data,
    output logic             rx_rd,
    input  logic             tx_full,
    output logic             tx_wr,
    output logic [DBIT-1:0]  tx_data,
    output logic [DBIT-1:0]  alu_a,
    output logic [DBIT-1:0]  alu_b,
    output logic [NB_OP-1:0] alu_op,
    input  logic [DBIT-1:0]  alu_result,
    output logic             busy,
    output logic             op_err,
    output logic             frame_err,
    output logic [2:0]       dbg_state
);

    typedef enum logic [2:0] {
        GET_A  = 3'd0,
        GET_B  = 3'd1,
        GET_OP = 3'd2,
        EXEC   = 3'd3,
        SEND   = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [DBIT-1:0]  r_alu_a;
    logic [DBIT-1:0]  r_alu_b;
    logic [NB_OP-1:0] r_alu_op;
    logic [DBIT-1:0]  r_tx_data;
    logic             r_busy;
    logic             r_op_err;
    logic             r_frame_err;

    logic             w_rx_rd;
    logic             w_tx_wr;
    logic             w_ld_a;
    logic             w_ld_b;
    logic             w_ld_op;
    logic             w_ld_tx;
    logic             w_op_err;
    logic             w_frame_err;
    logic             w_tmr_clr;
    logic             w_tmr_en;
    logic             w_expired;
    logic [NB_OP-1:0] w_op;

    assign w_op = rx_data[NB_OP-1:0];

    uart_alu_ctrl_frame_timer #(
        .TIMEOUT (TIMEOUT),
        .TW      (TW)
    ) u_frame_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (w_tmr_clr),
        .enable  (w_tmr_en),
        .expired (w_expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= GET_A;
        end else begin
            r_state <= w_next;
        end
    end

    // Handshake: a pop is only issued while rx_empty=0, a push only while tx_full=0,
    // and the FSM never pops and pushes in the same state, so they are exclusive.
    always_comb begin
        w_next      = r_state;
        w_rx_rd     = 1'b0;
        w_tx_wr     = 1'b0;
        w_ld_a      = 1'b0;
        w_ld_b      = 1'b0;
        w_ld_op     = 1'b0;
        w_ld_tx     = 1'b0;
        w_op_err    = 1'b0;
        w_frame_err = 1'b0;
        w_tmr_clr   = 1'b0;
        w_tmr_en    = 1'b0;
        case (r_state)
            GET_A: begin
                w_tmr_clr = 1'b1;
                if (!rx_empty) begin
                    w_rx_rd = 1'b1;
                    w_ld_a  = 1'b1;
                    w_next  = GET_B;
                end
            end
            GET_B: begin
                if (!rx_empty) begin
                    w_rx_rd   = 1'b1;
                    w_ld_b    = 1'b1;
                    w_tmr_clr = 1'b1;
                    w_next    = GET_OP;
                end else if (w_expired) begin
                    w_frame_err = 1'b1;
                    w_next      = GET_A;
                end else begin
                    w_tmr_en = 1'b1;
                end
            end
            GET_OP: begin
                if (!rx_empty) begin
                    w_rx_rd   = 1'b1;
                    w_tmr_clr = 1'b1;
                    if (is_legal_op(w_op)) begin
                        w_ld_op = 1'b1;
                        w_next  = EXEC;
                    end else begin
                        w_op_err = 1'b1;
                        w_next   = GET_A;
                    end
                end else if (w_expired) begin
                    w_frame_err = 1'b1;
                    w_next      = GET_A;
                end else begin
                    w_tmr_en = 1'b1;
                end
            end
            EXEC: begin
                w_ld_tx = 1'b1;
                w_next  = SEND;
            end
            SEND: begin
                if (!tx_full) begin
                    w_tx_wr = 1'b1;
                    w_next  = GET_A;
                end
            end
            default: begin
                w_next = GET_A;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_op    <= '0;
            r_tx_data   <= '0;
            r_busy      <= 1'b0;
            r_op_err    <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            if (w_ld_a) begin
                r_alu_a <= rx_data;
            end
            if (w_ld_b) begin
                r_alu_b <= rx_data;
            end
            if (w_ld_op) begin
                r_alu_op <= w_op;
            end
            if (w_ld_tx) begin
                r_tx_data <= alu_result;
            end
            r_busy      <= (w_next != GET_A);
            r_op_err    <= w_op_err;
            r_frame_err <= w_frame_err;
        end
    end

    // Strobes are gated by reset so no FIFO is touched while reset is held.
    assign rx_rd     = w_rx_rd & ~reset;
    assign tx_wr     = w_tx_wr & ~reset;
    assign tx_data   = r_tx_data;
    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign alu_op    = r_alu_op;
    assign busy      = r_busy;
    assign op_err    = r_op_err;
    assign frame_err = r_frame_err;
    assign dbg_state = r_state;

endmodule

// File: doc/uart_alu_ctrl.md
Name: uart_alu_ctrl

Overview:
- Sequencer between the UART receive FIFO, the combinational ALU and the UART transmit FIFO.
- Pops a 3-byte frame from the RX FIFO in the order operand A, operand B, opcode, and drives the ALU from registered operands.
- Pushes the one-byte result into the TX FIFO.
- Discards stalled partial frames by timeout and drops frames with illegal opcodes.

Parameters:
- DBIT, 8, data/operand width; equals the FIFO word width B.
- NB_OP, 6, opcode width; the opcode is the low NB_OP bits of the third byte.
- TIMEOUT, 50000, clk cycles allowed between consecutive bytes of one frame; must be ≥2.
- TW, 16, timeout counter width; 2**TW > TIMEOUT.

Ports:
- clk  in  1  system clock
- reset  in  1  reset
- rx_empty  in  1  RX FIFO empty flag
- rx_data  in  DBIT  RX FIFO head word, valid whenever rx_empty=0
- rx_rd  out  1  RX FIFO pop, one cycle per byte
- tx_full  in  1  TX FIFO full flag
- tx_wr  out  1  TX FIFO push, one cycle per result
- tx_data  out  DBIT  result byte to TX FIFO
- alu_a  out  DBIT  registered operand A
- alu_b  out  DBIT  registered operand B
- alu_op  out  NB_OP  registered opcode
- alu_result  in  DBIT  combinational ALU output
- busy  out  1  high while a frame is partially received or not yet sent
- op_err  out  1  one-cycle pulse: illegal opcode, frame dropped
- frame_err  out  1  one-cycle pulse: inter-byte timeout, partial frame dropped

Behaviour:
- Clock and reset: reset reset, asynchronous, active-high; clock clk.
- Reset values: state=GET_A; alu_a, alu_b, alu_op, tx_data, timer = 0; rx_rd, tx_wr, busy, op_err, frame_err = 0.
- rx_rd and tx_wr are combinational from state and flags. All other outputs are registered.
- States: GET_A, GET_B, GET_OP, EXEC, SEND.
- GET_A:
  - If rx_empty=0: rx_rd=1, alu_a<=rx_data, timer<=0, go to GET_B.
  - Otherwise stay. No timeout runs in GET_A.
- GET_B:
  - If rx_empty=0: rx_rd=1, alu_b<=rx_data, timer<=0, go to GET_OP.
  - Otherwise timer<=timer+1.
  - When timer==TIMEOUT-1 with rx_empty=1: frame_err<=1 for one cycle, go to GET_A.
- GET_OP, rx_empty=0, opcode legal: rx_rd=1, alu_op<=rx_data[NB_OP-1:0], go to EXEC.
- GET_OP, rx_empty=0, opcode illegal:
  - rx_rd=1 (the byte is consumed), op_err<=1 for one cycle, go to GET_A.
  - alu_op is unchanged; no TX write occurs.
- GET_OP, rx_empty=1: timeout exactly as in GET_B.
- EXEC: tx_data<=alu_result, unconditional go to SEND. This gives one settle cycle for the ALU.
- SEND:
  - If tx_full=0: tx_wr=1, go to GET_A.
  - If tx_full=1: hold with tx_data stable, indefinitely; no timeout in SEND.
- Legal opcodes: ADD 100000, SUB 100010, AND 100100, OR 100101, XOR 100110, NOR 100111, SRA 000011, SRL 000010.
- Latency: opcode pop in cycle N → EXEC in N+1 → tx_wr=1 in N+2 when tx_full=0.
- Throughput: 5 cycles per frame minimum, with back-to-back bytes available.
- busy=1 in every state except GET_A.
- Flag rules:
  - Only one of rx_rd and tx_wr is ever high in a cycle.
  - Never pop while rx_empty=1. Never push while tx_full=1.
- Timer saturates at TIMEOUT-1. Unused upper bits of the opcode byte are ignored.
- Reset mid-frame: the partial frame is lost, state returns to GET_A, and FIFO contents are untouched.
- A result pending in SEND at reset is lost.

Decomposition:
- Shared header alu_defs.vh: the opcode localparams listed above, DBIT and NB_OP defaults. The ALU and this block both include it.
- State encodings stay local to this module.
- One natural sub-module: frame_timer.
  - Inputs: clear, enable. Output: expired.
  - Parameters: TIMEOUT and TW.
  - Instantiated once.

Test Plan:
- Frame bytes 0x05, 0x03, 0x20 preloaded in the RX model, ALU model is real adder:
  - rx_rd high 3 consecutive cycles.
  - alu_a=0x05, alu_b=0x03, alu_op=6'h20.
  - tx_wr=1 exactly 2 cycles after the third pop, with tx_data=0x08.
- Two frames back-to-back (0xF0,0x0F,0x25 then 0x80,0x01,0x03):
  - Two pushes 5 cycles apart, tx_data 0xFF then 0xC0.
- Bytes 0x01, 0x02, then no third byte for TIMEOUT cycles (TIMEOUT=8 in bench):
  - frame_err pulses once, busy drops, no tx_wr.
  - A following frame 0x02,0x02,0x22 yields tx_data=0x00.
- Frame 0x07, 0x01, 0x3F:
  - op_err pulses once, three pops, no tx_wr.
  - The next legal frame is processed normally.
- tx_full held at 1 for 20 cycles during SEND:
  - tx_wr stays 0 and tx_data stays stable.
  - Release tx_full → exactly one push of that value.
- reset asserted in GET_OP after two pops:
  - All outputs are at reset values in the same cycle.
  - After release, a full new frame is required before any tx_wr.
